// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S receiver.
package i2s_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int SLOT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_e;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for one asynchronous input, followed by registered
// rising/falling edge pulses aligned with the delayed level output.
module i2s_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserializes left/right words and presents them as a
// valid/ready pair. Define I2S_RX_ERR_CNT_EN to add the saturating err_cnt output.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              lrck,
    input  logic              sdin,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int               CNT_W   = $clog2(SLOT_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W + 1);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_sck_level;
    logic w_lr_rise;
    logic w_lr_fall;
    logic w_lr_level;
    logic w_sdin;
    logic w_sd_rise;
    logic w_sd_fall;
    logic w_unused;

    i2s_sync u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .i_din   (sck),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    i2s_sync u_sync_lrck (
        .clk     (clk),
        .rst     (rst),
        .i_din   (lrck),
        .o_level (w_lr_level),
        .o_rise  (w_lr_rise),
        .o_fall  (w_lr_fall)
    );

    i2s_sync u_sync_sdin (
        .clk     (clk),
        .rst     (rst),
        .i_din   (sdin),
        .o_level (w_sdin),
        .o_rise  (w_sd_rise),
        .o_fall  (w_sd_fall)
    );

    assign w_unused = ^{w_sck_level, w_sck_fall, w_lr_level, w_sd_rise, w_sd_fall};

    state_e            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_out_left;
    logic [DATA_W-1:0] r_out_right;
    logic              r_valid;
    logic              r_overrun;
    logic [DATA_W-1:0] w_word_next;
    logic              w_shift_en;
    logic              w_pair_done;
    logic              w_drop;

    // Count 0 is the I2S one-bit delay; count k places bit k at MSB-(k-1), so
    // short words arrive left-justified over the zeros cleared at each lrck edge.
    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_word_next = r_word;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(r_bit_cnt) == DATA_W - i) begin
                w_word_next[i] = w_sdin;
            end
        end
    end

    assign w_shift_en  = (r_state != IDLE) && w_sck_rise;
    assign w_pair_done = (r_state == RIGHT) && w_lr_fall;
    assign w_drop      = w_pair_done && r_valid && !out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_word      <= '0;
            r_hold      <= '0;
            r_out_left  <= '0;
            r_out_right <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_shift_en) begin
                r_word <= w_word_next;
                if (r_bit_cnt != CNT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_lr_fall) begin
                        r_state   <= LEFT;
                        r_word    <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                LEFT: begin
                    if (w_lr_rise) begin
                        r_state   <= RIGHT;
                        r_hold    <= r_word;
                        r_word    <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                RIGHT: begin
                    if (w_lr_fall) begin
                        r_state   <= LEFT;
                        r_word    <= '0;
                        r_bit_cnt <= '0;
                        // A pair completing during the handshake cycle replaces the accepted one.
                        if (w_drop) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_out_left  <= r_hold;
                            r_out_right <= r_word;
                            r_valid     <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_left  = r_out_left;
    assign out_right = r_out_right;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_drop && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: table-driven and random frames against a
// word-level reference, plus backpressure, same-cycle handshake and reset sequences.
module tb_i2s_rx;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef struct {
        word_t left;
        word_t right;
    } pair_t;

    typedef struct {
        word_t left;
        word_t right;
        int    slot_l;
        int    slot_r;
        word_t exp_left;
        word_t exp_right;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  sck;
    logic  lrck;
    logic  sdin;
    logic  out_ready;
    word_t out_left;
    word_t out_right;
    logic  out_valid;
    logic  overrun;
`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    always #5 clk = ~clk;

    i2s_rx #(
        .DATA_W (DATA_W),
        .SLOT_W (SLOT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .lrck      (lrck),
        .sdin      (sdin),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
`ifdef I2S_RX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    int    vectors     = 0;
    int    miscompares = 0;
    int    n_pushed    = 0;
    int    n_accepted  = 0;
    int    n_overrun   = 0;
    pair_t exp_q[$];
    pair_t mon_pair;
    word_t hold_l;
    word_t hold_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: a slot of n sck cycles carries n-1 data bits after the delay bit;
    // only the first min(n-1, DATA_W) bits of the word survive, the rest read as 0.
    function automatic word_t exp_word(input word_t w, input int slot);
        int n;
        n = slot - 1;
        if (n >= DATA_W) return w;
        if (n <= 0) return '0;
        return w & ~((word_t'(1) << (DATA_W - n)) - word_t'(1));
    endfunction

    // Scoreboard: every accepted pair must be the oldest expected one.
    always @(negedge clk) begin
        if (rst && overrun) n_overrun++;
        if (rst && out_valid && out_ready) begin
            n_accepted++;
            check("pair_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_pair = exp_q.pop_front();
                check("out_left", out_left, mon_pair.left);
                check("out_right", out_right, mon_pair.right);
            end
        end
    end

    task automatic start_hook(input int mode);
        if (mode == 1) begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("same_cycle_valid", out_valid, 1);
            check("same_cycle_left", out_left, hold_l);
            check("same_cycle_right", out_right, hold_r);
        end else if (mode == 2) begin
            repeat (3) @(posedge clk);
            #1 check("latency_early", out_valid, 0);
            @(posedge clk);
            #1 check("latency_valid", out_valid, 1);
        end
    endtask

    task automatic mid_hook(input int mode);
        if (mode == 3) begin
            rst = 1'b0;
            repeat (2) @(negedge clk);
            check("midrst_left", out_left, 0);
            check("midrst_right", out_right, 0);
            check("midrst_valid", out_valid, 0);
            check("midrst_overrun", overrun, 0);
            rst = 1'b1;
            out_ready = 1'b1;
        end else if (mode == 4) begin
            check("hold_left", out_left, hold_l);
            check("hold_right", out_right, hold_r);
            check("hold_valid", out_valid, 1);
            check("overrun_count", n_overrun, 1);
`ifdef I2S_RX_ERR_CNT_EN
            check("err_cnt", err_cnt, 1);
`endif
            out_ready = 1'b1;
        end
    endtask

    // One lrck half-period of `slot` sck cycles; lrck and sdin change while sck is low.
    task automatic send_half(input logic lr, input word_t w, input int slot, input int mode);
        lrck = lr;
        sdin = 1'($urandom);
        for (int b = 0; b < slot; b++) begin
            fork
                repeat (4) @(negedge clk);
                if (b == 0) start_hook(mode);
            join
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            if (b + 1 <= DATA_W) sdin = w[DATA_W-1-b];
            else sdin = 1'($urandom);
            if (b == 8) mid_hook(mode);
        end
    endtask

    task automatic push_pair(input word_t l, input word_t r);
        pair_t p;
        p.left  = l;
        p.right = r;
        exp_q.push_back(p);
        n_pushed++;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[$];
        vec_t  v;
        word_t wa_l, wa_r, wb_l, wb_r, wc_l, wc_r, wd_l, wd_r;
        word_t we_l, we_r, wf_l, wf_r, wg_l, wg_r, wh_l, wh_r;

        tbl.push_back('{24'hA5A5A5, 24'h5A5A5A, 32, 32, 24'hA5A5A5, 24'h5A5A5A});
        tbl.push_back('{24'hFFFFFF, 24'hFFFFFF, 19, 19, 24'hFFFFC0, 24'hFFFFC0});
        tbl.push_back('{24'h123456, 24'hABCDEF, 13,  5, 24'h123000, 24'hA00000});
        tbl.push_back('{24'h800001, 24'h000001, 25, 25, 24'h800001, 24'h000001});
        tbl.push_back('{24'hC3C3C3, 24'h3C3C3C, 70, 40, 24'hC3C3C3, 24'h3C3C3C});
        tbl.push_back('{24'hFFFFFF, 24'hFFFFFF,  2,  1, 24'h800000, 24'h000000});
        tbl.push_back('{24'h7FFFFF, 24'h800000, 24, 33, 24'h7FFFFE, 24'h800000});
        tbl.push_back('{24'hA5A5A5, 24'h5A5A5A, 32, 32, 24'hA5A5A5, 24'h5A5A5A});
        for (int i = 0; i < 10; i++) begin
            v.left      = word_t'($urandom);
            v.right     = word_t'($urandom);
            v.slot_l    = $urandom_range(2, 40);
            v.slot_r    = $urandom_range(2, 40);
            v.exp_left  = exp_word(v.left, v.slot_l);
            v.exp_right = exp_word(v.right, v.slot_r);
            tbl.push_back(v);
        end

        rst       = 1'b0;
        sck       = 1'b0;
        lrck      = 1'b1;
        sdin      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_left", out_left, 0);
        check("reset_right", out_right, 0);
        check("reset_valid", out_valid, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Start inside a right slot: this partial frame must never be reported.
        send_half(1'b1, word_t'($urandom), 12, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            send_half(1'b0, tbl[i].left, tbl[i].slot_l, (i == 1) ? 2 : 0);
            send_half(1'b1, tbl[i].right, tbl[i].slot_r, 0);
            push_pair(tbl[i].exp_left, tbl[i].exp_right);
        end

        wa_l = word_t'($urandom); wa_r = word_t'($urandom);
        wb_l = word_t'($urandom); wb_r = word_t'($urandom);
        wc_l = word_t'($urandom); wc_r = word_t'($urandom);
        wd_l = word_t'($urandom); wd_r = word_t'($urandom);
        we_l = word_t'($urandom); we_r = word_t'($urandom);
        wf_l = word_t'($urandom); wf_r = word_t'($urandom);
        wg_l = word_t'($urandom); wg_r = word_t'($urandom);
        wh_l = word_t'($urandom); wh_r = word_t'($urandom);

        // Backpressure over two frames: A is held, B is dropped with one overrun.
        send_half(1'b0, wa_l, 32, 0);
        out_ready = 1'b0;
        send_half(1'b1, wa_r, 32, 0);
        push_pair(wa_l, wa_r);
        hold_l = wa_l;
        hold_r = wa_r;
        send_half(1'b0, wb_l, 32, 0);
        send_half(1'b1, wb_r, 32, 0);
        send_half(1'b0, wc_l, 32, 4);
        out_ready = 1'b0;
        send_half(1'b1, wc_r, 32, 0);
        push_pair(wc_l, wc_r);

        // C held; ready rises in the very cycle D completes.
        send_half(1'b0, wd_l, 32, 0);
        send_half(1'b1, wd_r, 32, 0);
        push_pair(wd_l, wd_r);
        hold_l = wd_l;
        hold_r = wd_r;
        send_half(1'b0, we_l, 32, 1);
        check("no_overrun_same_cycle", n_overrun, 1);

        // E is held, then reset in the middle of F's right slot wipes everything.
        out_ready = 1'b0;
        send_half(1'b1, we_r, 32, 0);
        send_half(1'b0, wf_l, 32, 0);
        send_half(1'b1, wf_r, 32, 3);
        send_half(1'b0, wg_l, 32, 0);
        send_half(1'b1, wg_r, 32, 0);
        push_pair(wg_l, wg_r);
        send_half(1'b0, wh_l, 32, 0);
        send_half(1'b1, wh_r, 32, 0);
        push_pair(wh_l, wh_r);
        send_half(1'b0, word_t'($urandom), 4, 0);
        repeat (20) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        check("pairs_accepted", n_accepted, n_pushed);
        check("overrun_total", n_overrun, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, sample width in bits per channel.
REQ-002 SHALL have parameter SLOT_W, default 32, maximum sck cycles per lrck half-period; bit counter sized to hold it.
REQ-003 SHALL have port clk, input, 1, system clock; all logic is on its rising edge; frequency at least 4x sck.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port sck, input, 1, external bit clock; asynchronous to clk.
REQ-006 SHALL have port lrck, input, 1, word select (0=left, 1=right); asynchronous to clk.
REQ-007 SHALL have port sdin, input, 1, serial data from the ADC, MSB first.
REQ-008 SHALL have port out_left, output, DATA_W, last complete left sample.
REQ-009 SHALL have port out_right, output, DATA_W, last complete right sample.
REQ-010 SHALL have port out_valid, output, 1, a left/right pair is held on out_left/out_right.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the pair.
REQ-012 SHALL have port overrun, output, 1, one-clk pulse when a completed frame is dropped.

Function
REQ-013 SHALL pass sck, lrck and sdin each through a 2-flop synchronizer, then detect sck rising edges and lrck rising and falling edges on the synchronized values.
REQ-014 SHALL implement states IDLE, LEFT and RIGHT; IDLE -> LEFT on an lrck falling edge; LEFT -> RIGHT on an lrck rising edge; RIGHT -> LEFT on an lrck falling edge. lrck rising edges in IDLE SHALL be ignored.
REQ-015 SHALL discard the first sck rising edge after each lrck edge (I2S one-bit delay), then shift sdin into a DATA_W shift register, MSB first, on each following sck rising edge.
REQ-016 SHALL stop shifting after DATA_W bits; extra bits up to SLOT_W SHALL be ignored; bits beyond SLOT_W SHALL also be ignored, and the bit counter SHALL saturate, not wrap.
REQ-017 SHALL zero-fill the LSBs when fewer than DATA_W bits arrive before the next lrck edge (left-justified).
REQ-018 SHALL latch the left word into a holding register on the LEFT -> RIGHT transition.
REQ-019 SHALL, on the RIGHT -> LEFT transition, load out_left and out_right with the held left word and the right word, and assert out_valid 3 clk cycles after the first clk edge that samples lrck low at the pin.
REQ-020 SHALL hold out_valid, out_left and out_right stable until the cycle in which out_valid and out_ready are both high; out_valid SHALL clear the following cycle unless a new pair loads in that cycle.
REQ-021 SHALL load the new pair and keep out_valid high when a pair completes in the same cycle as the handshake.
REQ-022 SHALL, when a pair completes while out_valid=1 and out_ready=0, drop the new pair, keep the old output unchanged, and pulse overrun for 1 cycle.
REQ-023 SHALL produce no output from the partial frame that follows leaving IDLE; the first pair is emitted only after one complete LEFT and RIGHT.

Reset
REQ-024 SHALL, while rst=0, set state IDLE, clear the synchronizers, shift register, counters and holding register, and drive out_left=0, out_right=0, out_valid=0, overrun=0.
REQ-025 SHALL, after a reset during a frame, discard that frame and resume only from the next lrck falling edge.

Configuration
REQ-026 SHALL, with I2S_RX_ERR_CNT_EN defined, add output err_cnt [7:0]: it increments on each overrun pulse, saturates at 255 and resets to 0.
REQ-027 SHALL, without I2S_RX_ERR_CNT_EN, have no err_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-028 SHALL take the default DATA_W and SLOT_W constants and the state enum (IDLE/LEFT/RIGHT) from the shared package i2s_pkg.
REQ-029 SHALL place the synchronizer and edge detector in one sub-module, i2s_sync, instantiated once per input.

Verification
REQ-030 SHALL check: stream left=24'hA5A5A5 and right=24'h5A5A5A with out_ready=1 -> out_left=A5A5A5 and out_right=5A5A5A, out_valid pulses once per frame.
REQ-031 SHALL check: 18 data bits 18'h3FFFF per channel -> outputs 24'hFFFFC0.
REQ-032 SHALL check: out_ready=0 over two frames -> first pair held, one overrun pulse, err_cnt=1 with the macro defined.
REQ-033 SHALL check: out_ready rises in the same cycle a new pair completes -> new pair shown, out_valid stays 1, no overrun.
REQ-034 SHALL check: rst=0 mid-RIGHT -> all outputs 0; the next pair appears only after a full frame following the next lrck falling edge.
REQ-035 SHALL check: start the bench with lrck=1 mid-right-slot -> the first partial frame is discarded and the first out_valid is a correct complete pair.
